// File: rtl/sysid_avm_if.sv
// Avalon-MM read-only link between the boot checker
// and the sysid control slave.
interface sysid_avm_if;
  logic        address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid checker: reads ID and timestamp words
// over Avalon-MM and flags mismatches or stalled reads.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1353056389,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  sysid_avm_if.master  avm,
  output logic [31:0]  id_value,
  output logic [31:0]  timestamp_value,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         fail_id,
  output logic         fail_ts,
  output logic         timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_ID = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_REQ_TS = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_CMP    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [15:0] WAIT_LAST =
    16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST  =
    2'(READ_LATENCY - 1);
  localparam bit NO_LAT = (READ_LATENCY == 0);

  logic [2:0]  state;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;
  logic        armed;
  logic        id_bad;
  logic        ts_bad;
  logic        accept;
  logic        stall_out;

  assign avm.read    = (state == S_REQ_ID) ||
                       (state == S_REQ_TS);
  assign avm.address = (state == S_REQ_TS);
  assign busy        = (state != S_IDLE) &&
                       (state != S_DONE);
  assign done        = (state == S_DONE);

  assign accept    = avm.read && !avm.waitrequest;
  assign stall_out = avm.waitrequest &&
                     (wait_cnt == WAIT_LAST);

  assign id_bad = (id_value != EXPECTED_ID);
  assign ts_bad = CHECK_TIMESTAMP &&
                  (timestamp_value != EXPECTED_TIMESTAMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      armed           <= AUTO_START;
      wait_cnt        <= '0;
      lat_cnt         <= '0;
      id_value        <= '0;
      timestamp_value <= '0;
      pass            <= 1'b0;
      fail_id         <= 1'b0;
      fail_ts         <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      armed <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start || armed) begin
            state           <= S_REQ_ID;
            wait_cnt        <= '0;
            id_value        <= '0;
            timestamp_value <= '0;
            pass            <= 1'b0;
            fail_id         <= 1'b0;
            fail_ts         <= 1'b0;
            timeout         <= 1'b0;
          end
        end
        S_REQ_ID: begin
          if (accept) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
            if (NO_LAT) begin
              id_value <= avm.readdata;
              state    <= S_REQ_TS;
            end else begin
              state <= S_LAT_ID;
            end
          end else if (stall_out) begin
            timeout <= 1'b1;
            fail_id <= 1'b1;
            state   <= S_DONE;
          end else if (avm.waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_LAT_ID: begin
          if (lat_cnt == LAT_LAST) begin
            id_value <= avm.readdata;
            wait_cnt <= '0;
            state    <= S_REQ_TS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_REQ_TS: begin
          if (accept) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
            if (NO_LAT) begin
              timestamp_value <= avm.readdata;
              state           <= S_CMP;
            end else begin
              state <= S_LAT_TS;
            end
          end else if (stall_out) begin
            timeout <= 1'b1;
            fail_ts <= 1'b1;
            state   <= S_DONE;
          end else if (avm.waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_LAT_TS: begin
          if (lat_cnt == LAT_LAST) begin
            timestamp_value <= avm.readdata;
            state           <= S_CMP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_CMP: begin
          fail_id <= id_bad;
          fail_ts <= ts_bad;
          pass    <= !(id_bad || ts_bad);
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: two DUT configurations,
// modelled sysid slaves and an expected-result scoreboard.
module tb_sysid_boot_checker;

  localparam logic [31:0] TS_OK  = 32'd1353056389;
  localparam logic [31:0] TS_BAD = 32'd1353056390;

  typedef struct {
    int          inst;
    bit          ok;
    bit          fid;
    bit          fts;
    bit          tmo;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  start_v, done_v, busy_v, pass_v;
  logic [1:0]  fid_v, fts_v, tmo_v, rd_v;
  logic [31:0] idv [2];
  logic [31:0] tsv [2];
  logic [31:0] id_word [2];
  logic [31:0] ts_word [2];
  int          stall_id [2];
  int          stall_ts [2];
  bit          stuck [2];

  int cyc = 0;
  int sedge = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 0 : 2;
    sysid_avm_if bus ();
    logic       wr;
    int         waited;
    logic [2:0] pv;
    logic [2:0] pa;
    logic       hold;
    logic       prev_a;
    int         addr_bad = 0;

    sysid_boot_checker #(
      .READ_LATENCY    (RL),
      .CHECK_TIMESTAMP (1'(g == 0)),
      .AUTO_START      (1'(g == 0))
    ) dut (
      .clock           (clk),
      .reset_n         (rst_n),
      .start           (start_v[g]),
      .avm             (bus),
      .id_value        (idv[g]),
      .timestamp_value (tsv[g]),
      .busy            (busy_v[g]),
      .done            (done_v[g]),
      .pass            (pass_v[g]),
      .fail_id         (fid_v[g]),
      .fail_ts         (fts_v[g]),
      .timeout         (tmo_v[g])
    );

    assign wr = bus.read && (stuck[g] || waited <
      (bus.address ? stall_ts[g] : stall_id[g]));
    assign bus.waitrequest = wr;
    assign rd_v[g] = bus.read;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        waited <= 0;
        pv     <= '0;
        pa     <= '0;
        hold   <= 1'b0;
        prev_a <= 1'b0;
      end else begin
        waited <= wr ? waited + 1 : 0;
        pv     <= {pv[1:0], bus.read && !wr};
        pa     <= {pa[1:0], bus.address};
        hold   <= wr;
        prev_a <= bus.address;
      end
    end

    always @(negedge clk)
      if (rst_n && hold && bus.read &&
          bus.address != prev_a)
        addr_bad <= addr_bad + 1;

    if (RL == 0) begin : g_rl0
      assign bus.readdata =
        bus.address ? ts_word[g] : id_word[g];
    end else begin : g_rln
      assign bus.readdata = pv[RL-1] ?
        (pa[RL-1] ? ts_word[g] : id_word[g]) :
        32'hDEADBEEF;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t mk(
    input int inst, input bit ok, input bit fid,
    input bit fts, input bit tmo,
    input logic [31:0] id, input logic [31:0] ts,
    input int lat);
    exp_t e;
    e.inst = inst; e.ok = ok; e.fid = fid;
    e.fts = fts; e.tmo = tmo; e.id = id;
    e.ts = ts; e.lat = lat;
    return e;
  endfunction

  task automatic kick(input int g);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    sedge = cyc;
    check("clr_done", 32'(done_v[g]), 0);
    check("clr_id", idv[g], 0);
    check("busy_run", 32'(busy_v[g]), 1);
  endtask

  task automatic wait_done(input int g);
    exp_t e;
    int n = 0;
    while (!done_v[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!done_v[g]) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("inst", g, e.inst);
    check("latency", cyc - sedge, e.lat);
    check("pass", 32'(pass_v[g]), 32'(e.ok));
    check("fail_id", 32'(fid_v[g]), 32'(e.fid));
    check("fail_ts", 32'(fts_v[g]), 32'(e.fts));
    check("timeout", 32'(tmo_v[g]), 32'(e.tmo));
    check("id_value", idv[g], e.id);
    check("ts_value", tsv[g], e.ts);
    check("busy_done", 32'(busy_v[g]), 0);
    check("read_idle", 32'(rd_v[g]), 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sedge = cyc;
  endtask

  initial begin
    rst_n    = 1'b0;
    start_v  = '0;
    id_word  = '{32'd0, 32'd0};
    ts_word  = '{TS_OK, TS_OK};
    stall_id = '{0, 0};
    stall_ts = '{0, 0};
    stuck    = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_done", 32'(done_v[g]), 0);
      check("rst_pass", 32'(pass_v[g]), 0);
      check("rst_busy", 32'(busy_v[g]), 0);
      check("rst_read", 32'(rd_v[g]), 0);
      check("rst_flags",
            32'({fid_v[g], fts_v[g], tmo_v[g]}), 0);
    end

    // auto-start run on the zero-latency instance
    sb.push_back(mk(0, 1, 0, 0, 0, 0, TS_OK, 3));
    release_rst();
    wait_done(0);
    check("b_idle", 32'(busy_v[1] | done_v[1]), 0);

    // timestamp mismatch, checked
    ts_word[0] = TS_BAD;
    sb.push_back(mk(0, 0, 0, 1, 0, 0, TS_BAD, 3));
    kick(0);
    wait_done(0);
    ts_word[0] = TS_OK;

    // ID mismatch
    id_word[0] = 32'd5;
    sb.push_back(mk(0, 0, 1, 0, 0, 5, TS_OK, 3));
    kick(0);
    wait_done(0);
    id_word[0] = 32'd0;

    // latency 2, three stall cycles on word 0
    stall_id[1] = 3;
    sb.push_back(mk(1, 1, 0, 0, 0, 0, TS_OK, 10));
    kick(1);
    wait_done(1);
    check("addr_stable", g_dut[1].addr_bad, 0);
    stall_id[1] = 0;

    // timestamp mismatch not checked on instance 1
    ts_word[1] = TS_BAD;
    sb.push_back(mk(1, 1, 0, 0, 0, 0, TS_BAD, 7));
    kick(1);
    wait_done(1);
    ts_word[1] = TS_OK;

    // stuck slave -> timeout on word 0
    stuck[0] = 1'b1;
    sb.push_back(mk(0, 0, 1, 0, 1, 0, 0, 255));
    kick(0);
    wait_done(0);
    stuck[0] = 1'b0;

    // start during REQ_TS stall and on the accept edge
    stall_ts[0] = 2;
    sb.push_back(mk(0, 1, 0, 0, 0, 0, TS_OK, 5));
    kick(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done_v[0]), 1);
    check("addr_stable_a", g_dut[0].addr_bad, 0);

    // rerun from DONE
    stall_ts[0] = 0;
    sb.push_back(mk(0, 1, 0, 0, 0, 0, TS_OK, 3));
    kick(0);
    wait_done(0);

    // reset during REQ_TS stall
    id_word[0]  = 32'h1234;
    stall_ts[0] = 1000;
    kick(0);
    repeat (4) @(negedge clk);
    check("pre_rst_read", 32'(rd_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_read", 32'(rd_v[0]), 0);
    check("arst_busy", 32'(busy_v[0]), 0);
    check("arst_id", idv[0], 0);
    check("arst_done", 32'(done_v[0]), 0);
    id_word[0]  = 32'd0;
    stall_ts[0] = 0;
    sb.push_back(mk(0, 1, 0, 0, 0, 0, TS_OK, 3));
    release_rst();
    wait_done(0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
